// File: rtl/time_set_ctrl_pkg.sv
// rtl/time_set_ctrl_pkg.sv - select codes, FSM state encodings and field helpers for time_set_ctrl
package time_set_ctrl_pkg;

    localparam logic [1:0] SELECT_NONE = 2'b00;
    localparam logic [1:0] SELECT_SEC  = 2'b01;
    localparam logic [1:0] SELECT_MIN  = 2'b10;
    localparam logic [1:0] SELECT_HOUR = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_SEC  = 2'd3
    } state_t;

    function automatic state_t next_field(input state_t s);
        state_t n;
        case (s)
            ST_RUN:      n = ST_SET_HOUR;
            ST_SET_HOUR: n = ST_SET_MIN;
            ST_SET_MIN:  n = ST_SET_SEC;
            default:     n = ST_RUN;
        endcase
        return n;
    endfunction

    function automatic logic [1:0] select_of(input state_t s);
        logic [1:0] sel;
        case (s)
            ST_SET_HOUR: sel = SELECT_HOUR;
            ST_SET_MIN:  sel = SELECT_MIN;
            ST_SET_SEC:  sel = SELECT_SEC;
            default:     sel = SELECT_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer, debouncer and registered press detector for one button
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [1:0]    sync_vld;
    logic          level_d;
    logic          armed;
    logic [CW-1:0] cnt;

    // armed only after a genuinely released button has been seen, so a button
    // held across reset must be released and pressed again to count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync_vld <= 2'b00;
            level    <= 1'b0;
            level_d  <= 1'b0;
            armed    <= 1'b0;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            sync_vld <= {sync_vld[0], 1'b1};
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
            level_d <= level;
            if (sync_vld[1] && !level && !sync2) begin
                armed <= 1'b1;
            end
            press <= level && !level_d && armed;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - button-driven time-set FSM; define AUTO_REPEAT_EN for hold-to-repeat on adjust
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100,
    parameter int IDLE_TIMEOUT    = 5000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_adj,
    output logic [1:0] select,
    output logic       increment,
    output logic       setting
);

    localparam bit IDLE_EN = (IDLE_TIMEOUT > 0);
    localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TIMEOUT);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

    logic          mode_press;
    logic          adj_press;
    logic          adj_level;
    logic          unused_mode_level;
    state_t        state;
    state_t        state_next;
    logic          mode_pend;
    logic          mode_pend_next;
    logic [IW-1:0] idle_cnt;
    logic [IW-1:0] idle_next;
    logic          idle_hit;
    logic          adj_fire;
    logic          rep_fire;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn_mode),
        .level   (unused_mode_level),
        .press   (mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_adj_db (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn_adj),
        .level   (adj_level),
        .press   (adj_press)
    );

    // a mode press landing on a live increment is held for one cycle so select
    // stays put for the cycle after the pulse
    always_comb begin
        state_next     = state;
        mode_pend_next = 1'b0;
        idle_next      = idle_cnt;
        adj_fire       = 1'b0;
        if (state == ST_RUN || mode_press || adj_press || !IDLE_EN) begin
            idle_next = '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_next = idle_cnt + 1'b1;
        end
        idle_hit = IDLE_EN && (state != ST_RUN) && !mode_press && !adj_press
                   && (idle_cnt >= IDLE_LAST);
        if (mode_pend) begin
            state_next = next_field(state);
        end else if (mode_press) begin
            if (increment) begin
                mode_pend_next = 1'b1;
            end else begin
                state_next = next_field(state);
            end
        end else if (idle_hit && !increment) begin
            state_next = ST_RUN;
        end else if (adj_press && state != ST_RUN && !increment) begin
            adj_fire = 1'b1;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DELAY_LOAD  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LOAD = RW'(REPEAT_PERIOD - 1);

    logic          rep_active;
    logic          rep_active_next;
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_cnt_next;

    // countdown to the next repeat; a fire that would collide with a live pulse waits at zero
    always_comb begin
        rep_fire        = 1'b0;
        rep_active_next = rep_active;
        rep_cnt_next    = rep_cnt;
        if (adj_fire) begin
            rep_active_next = 1'b1;
            rep_cnt_next    = DELAY_LOAD;
        end else if (!rep_active || !adj_level || mode_press || mode_pend
                     || state_next != state) begin
            rep_active_next = 1'b0;
            rep_cnt_next    = '0;
        end else if (rep_cnt != '0) begin
            rep_cnt_next = rep_cnt - 1'b1;
        end else if (!increment) begin
            rep_fire     = 1'b1;
            rep_cnt_next = PERIOD_LOAD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_active <= 1'b0;
            rep_cnt    <= '0;
        end else begin
            rep_active <= rep_active_next;
            rep_cnt    <= rep_cnt_next;
        end
    end
`else
    logic unused_repeat_cfg;
    assign rep_fire          = 1'b0;
    assign unused_repeat_cfg = adj_level & ((REPEAT_DELAY + REPEAT_PERIOD) > 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RUN;
            select    <= SELECT_NONE;
            increment <= 1'b0;
            mode_pend <= 1'b0;
            idle_cnt  <= '0;
        end else begin
            state     <= state_next;
            select    <= select_of(state_next);
            increment <= adj_fire | rep_fire;
            mode_pend <= mode_pend_next;
            idle_cnt  <= idle_next;
        end
    end

    assign setting = (state != ST_RUN);

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - directed self-checking bench for time_set_ctrl
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_mode;
    logic       btn_adj;
    logic [1:0] select;
    logic       increment;
    logic       setting;

    int tests = 0;
    int fails = 0;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (4),
        .IDLE_TIMEOUT    (50)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_mode  (btn_mode),
        .btn_adj   (btn_adj),
        .select    (select),
        .increment (increment),
        .setting   (setting)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         pulse_cnt = 0;
    int         wide_cnt  = 0;
    int         pulse_cyc[$];
    logic       inc_prev  = 1'b0;
    logic [1:0] sel_d     = 2'b00;
    logic [1:0] pre_sel   = 2'b00;
    logic [1:0] pulse_sel = 2'b00;
    logic [1:0] post_sel  = 2'b00;

    always @(negedge clk) begin
        if (increment && !inc_prev) begin
            pulse_cnt++;
            pulse_cyc.push_back(cyc);
            pulse_sel = select;
            pre_sel   = sel_d;
        end
        if (increment && inc_prev) wide_cnt++;
        if (!increment && inc_prev) post_sel = select;
        inc_prev = increment;
        sel_d    = select;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset;
        reset_n  = 1'b0;
        btn_mode = 1'b0;
        btn_adj  = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(3);
    endtask

    task automatic press_mode;
        btn_mode = 1'b1;
        tick(9);
        btn_mode = 1'b0;
        tick(9);
    endtask

    task automatic press_adj;
        btn_adj = 1'b1;
        tick(9);
        btn_adj = 1'b0;
        tick(9);
    endtask

    task automatic test_reset;
        reset_n  = 1'b0;
        btn_mode = 1'b0;
        btn_adj  = 1'b0;
        tick(2);
        tests++; if (select !== 2'b00) begin fails++; $display("FAIL reset_select: got %b expected 00", select); end
        tests++; if (increment !== 1'b0) begin fails++; $display("FAIL reset_increment: got %b expected 0", increment); end
        tests++; if (setting !== 1'b0) begin fails++; $display("FAIL reset_setting: got %b expected 0", setting); end
        reset_n = 1'b1;
        tick(3);
    endtask

    task automatic test_clean_press;
        btn_mode = 1'b1;
        tick(7);
        tests++; if (select !== 2'b00) begin fails++; $display("FAIL clean_early_select: got %b expected 00", select); end
        tests++; if (setting !== 1'b0) begin fails++; $display("FAIL clean_early_setting: got %b expected 0", setting); end
        tick(1);
        tests++; if (select !== 2'b11) begin fails++; $display("FAIL clean_select: got %b expected 11", select); end
        tests++; if (setting !== 1'b1) begin fails++; $display("FAIL clean_setting: got %b expected 1", setting); end
        tick(2);
        btn_mode = 1'b0;
        tick(9);
    endtask

    task automatic test_bounce_adj;
        int p0;
        int w0;
        press_mode;
        tests++; if (select !== 2'b10) begin fails++; $display("FAIL bounce_enter_min: got %b expected 10", select); end
        p0 = pulse_cnt;
        w0 = wide_cnt;
        btn_adj = 1'b1; tick(1);
        btn_adj = 1'b0; tick(1);
        btn_adj = 1'b1; tick(1);
        btn_adj = 1'b0; tick(1);
        btn_adj = 1'b1; tick(8);
        btn_adj = 1'b0; tick(15);
        tests++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL bounce_pulses: got %0d expected 1", pulse_cnt - p0); end
        tests++; if (wide_cnt - w0 !== 0) begin fails++; $display("FAIL bounce_width: got %0d extra cycles expected 0", wide_cnt - w0); end
        tests++; if (pulse_sel !== 2'b10) begin fails++; $display("FAIL bounce_pulse_select: got %b expected 10", pulse_sel); end
    endtask

    task automatic test_mode_cycle;
        int p0;
        apply_reset;
        press_mode;
        tests++; if (select !== 2'b11) begin fails++; $display("FAIL cycle_hour: got %b expected 11", select); end
        press_mode;
        tests++; if (select !== 2'b10) begin fails++; $display("FAIL cycle_min: got %b expected 10", select); end
        press_mode;
        tests++; if (select !== 2'b01) begin fails++; $display("FAIL cycle_sec: got %b expected 01", select); end
        press_mode;
        tests++; if (select !== 2'b00) begin fails++; $display("FAIL cycle_run: got %b expected 00", select); end
        tests++; if (setting !== 1'b0) begin fails++; $display("FAIL cycle_setting: got %b expected 0", setting); end
        p0 = pulse_cnt;
        press_adj;
        tests++; if (pulse_cnt - p0 !== 0) begin fails++; $display("FAIL run_adj_ignored: got %0d pulses expected 0", pulse_cnt - p0); end
    endtask

    task automatic test_coincide;
        int p0;
        apply_reset;
        press_mode;
        p0 = pulse_cnt;
        btn_mode = 1'b1;
        btn_adj  = 1'b1;
        tick(9);
        btn_mode = 1'b0;
        btn_adj  = 1'b0;
        tick(9);
        tests++; if (select !== 2'b10) begin fails++; $display("FAIL coincide_select: got %b expected 10", select); end
        tests++; if (pulse_cnt - p0 !== 0) begin fails++; $display("FAIL coincide_pulses: got %0d expected 0", pulse_cnt - p0); end
    endtask

    task automatic test_pending_mode;
        int p0;
        apply_reset;
        press_mode;
        p0 = pulse_cnt;
        btn_adj = 1'b1;
        tick(1);
        btn_mode = 1'b1;
        tick(9);
        btn_mode = 1'b0;
        btn_adj  = 1'b0;
        tick(9);
        tests++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL pending_pulses: got %0d expected 1", pulse_cnt - p0); end
        tests++; if (pre_sel !== 2'b11) begin fails++; $display("FAIL pending_pre_select: got %b expected 11", pre_sel); end
        tests++; if (pulse_sel !== 2'b11) begin fails++; $display("FAIL pending_pulse_select: got %b expected 11", pulse_sel); end
        tests++; if (post_sel !== 2'b11) begin fails++; $display("FAIL pending_post_select: got %b expected 11", post_sel); end
        tests++; if (select !== 2'b10) begin fails++; $display("FAIL pending_final_select: got %b expected 10", select); end
    endtask

    task automatic test_repeat;
        int base;
        int p0;
        int w0;
        int c0;
        int exp_n;
        int exp_off[6];
        apply_reset;
        press_mode;
        base = pulse_cyc.size();
        p0   = pulse_cnt;
        w0   = wide_cnt;
        c0   = cyc;
`ifdef AUTO_REPEAT_EN
        exp_n   = 6;
        exp_off = '{0, 10, 14, 18, 22, 26};
`else
        exp_n   = 1;
        exp_off = '{0, 0, 0, 0, 0, 0};
`endif
        btn_adj = 1'b1;
        tick(30);
        btn_adj = 1'b0;
        tick(20);
        tests++; if (pulse_cnt - p0 !== exp_n) begin fails++; $display("FAIL repeat_count: got %0d expected %0d", pulse_cnt - p0, exp_n); end
        tests++; if (wide_cnt - w0 !== 0) begin fails++; $display("FAIL repeat_width: got %0d extra cycles expected 0", wide_cnt - w0); end
        if (pulse_cyc.size() > base) begin
            tests++; if (pulse_cyc[base] - c0 !== 8) begin fails++; $display("FAIL repeat_first_latency: got %0d expected 8", pulse_cyc[base] - c0); end
        end
        for (int i = 1; i < exp_n && base + i < pulse_cyc.size(); i++) begin
            tests++;
            if (pulse_cyc[base + i] - pulse_cyc[base] !== exp_off[i]) begin
                fails++;
                $display("FAIL repeat_offset_%0d: got %0d expected %0d", i, pulse_cyc[base + i] - pulse_cyc[base], exp_off[i]);
            end
        end
        tests++; if (pulse_sel !== 2'b11) begin fails++; $display("FAIL repeat_select: got %b expected 11", pulse_sel); end
    endtask

    task automatic test_timeout;
        bit found;
        apply_reset;
        press_mode;
        press_mode;
        found    = 1'b0;
        btn_mode = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1);
            if (select === 2'b01) found = 1'b1;
        end
        btn_mode = 1'b0;
        tests++; if (found !== 1'b1) begin fails++; $display("FAIL timeout_enter_sec: got %b expected select 01 within 20 cycles", select); end
        tick(49);
        tests++; if (select !== 2'b01) begin fails++; $display("FAIL timeout_early: got %b expected 01", select); end
        tick(1);
        tests++; if (select !== 2'b00) begin fails++; $display("FAIL timeout_select: got %b expected 00", select); end
        tests++; if (setting !== 1'b0) begin fails++; $display("FAIL timeout_setting: got %b expected 0", setting); end
    endtask

    task automatic test_held_mode;
        reset_n  = 1'b0;
        btn_mode = 1'b1;
        btn_adj  = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(20);
        tests++; if (select !== 2'b00) begin fails++; $display("FAIL held_mode_ignored: got %b expected 00", select); end
        btn_mode = 1'b0;
        tick(10);
        press_mode;
        tests++; if (select !== 2'b11) begin fails++; $display("FAIL held_mode_repress: got %b expected 11", select); end
    endtask

    task automatic test_reset_mid_pulse;
        bit found;
        int p0;
        found   = 1'b0;
        btn_adj = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1);
            if (increment === 1'b1) found = 1'b1;
        end
        tests++; if (found !== 1'b1) begin fails++; $display("FAIL midpulse_seen: got %b expected increment within 20 cycles", increment); end
        #2;
        reset_n = 1'b0;
        #1;
        tests++; if (increment !== 1'b0) begin fails++; $display("FAIL midpulse_async_drop: got %b expected 0", increment); end
        tests++; if (select !== 2'b00) begin fails++; $display("FAIL midpulse_select: got %b expected 00", select); end
        tests++; if (setting !== 1'b0) begin fails++; $display("FAIL midpulse_setting: got %b expected 0", setting); end
        tick(3);
        reset_n = 1'b1;
        p0 = pulse_cnt;
        tick(5);
        press_mode;
        tests++; if (select !== 2'b11) begin fails++; $display("FAIL midpulse_reenter: got %b expected 11", select); end
        tick(10);
        tests++; if (pulse_cnt - p0 !== 0) begin fails++; $display("FAIL held_adj_ignored: got %0d pulses expected 0", pulse_cnt - p0); end
        btn_adj = 1'b0;
        tick(10);
        press_adj;
        tests++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL held_adj_repress: got %0d pulses expected 1", pulse_cnt - p0); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        reset_n  = 1'b0;
        btn_mode = 1'b0;
        btn_adj  = 1'b0;
        test_reset;
        test_clean_press;
        test_bounce_adj;
        test_mode_cycle;
        test_coincide;
        test_pending_mode;
        test_repeat;
        test_timeout;
        test_held_mode;
        test_reset_mid_pulse;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
